// File: rtl/pong_game_ctrl.sv
// Pong game-flow controller: sequences serve, play, point pause, player pause
// and game over, and keeps both players' scores from the ball's boundary pulses.
module pong_game_ctrl #(
  parameter int WIN_SCORE   = 7,
  parameter int SERVE_TICKS = 60,
  parameter int POINT_TICKS = 90,
  parameter int TIMER_W     = 8,
  parameter int SCORE_W     = 4
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_tick,
  input  logic               i_start,
  input  logic               i_pause,
  input  logic               i_score_left,
  input  logic               i_score_right,
  output logic               o_ball_hold,
  output logic               o_ball_run,
  output logic               o_serve_dir,
  output logic [SCORE_W-1:0] o_left_score,
  output logic [SCORE_W-1:0] o_right_score,
  output logic               o_game_over,
  output logic               o_winner,
  output logic [2:0]         o_state
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SERVE     = 3'd1,
    S_PLAY      = 3'd2,
    S_POINT     = 3'd3,
    S_PAUSED    = 3'd4,
    S_GAME_OVER = 3'd5
  } state_t;

  localparam logic [TIMER_W-1:0] SERVE_LD = TIMER_W'(SERVE_TICKS);
  localparam logic [TIMER_W-1:0] POINT_LD = TIMER_W'(POINT_TICKS);
  localparam logic [TIMER_W-1:0] T_ONE    = TIMER_W'(1);
  localparam logic [SCORE_W-1:0] WIN      = SCORE_W'(WIN_SCORE);

  state_t               r_state, w_state_nxt;
  logic [TIMER_W-1:0]   r_timer, w_timer_nxt;
  logic [SCORE_W-1:0]   r_left, w_left_nxt;
  logic [SCORE_W-1:0]   r_right, w_right_nxt;
  logic                 r_dir, w_dir_nxt;
  logic                 r_winner, w_winner_nxt;
  logic                 r_start_q, r_pause_q;
  logic                 r_ball_hold, r_ball_run, r_game_over;
  logic                 w_start_rise, w_pause_rise;

  assign w_start_rise = i_start & ~r_start_q;
  assign w_pause_rise = i_pause & ~r_pause_q;

  always_comb begin
    w_state_nxt  = r_state;
    w_timer_nxt  = r_timer;
    w_left_nxt   = r_left;
    w_right_nxt  = r_right;
    w_dir_nxt    = r_dir;
    w_winner_nxt = r_winner;
    case (r_state)
      S_IDLE, S_GAME_OVER: begin
        if (w_start_rise) begin
          w_left_nxt  = '0;
          w_right_nxt = '0;
          w_dir_nxt   = 1'b0;
          w_timer_nxt = SERVE_LD;
          w_state_nxt = S_SERVE;
        end
      end
      S_SERVE: begin
        if (i_tick) begin
          w_timer_nxt = r_timer - 1'b1;
          if (r_timer == T_ONE) w_state_nxt = S_PLAY;
        end
      end
      S_PLAY: begin
        // Simultaneous boundary pulses are a glitch: no point, just re-serve.
        if (i_score_right && !i_score_left) begin
          if (r_left < WIN) w_left_nxt = r_left + 1'b1;
          w_dir_nxt   = 1'b0;
          w_timer_nxt = POINT_LD;
          w_state_nxt = S_POINT;
        end else if (i_score_left && !i_score_right) begin
          if (r_right < WIN) w_right_nxt = r_right + 1'b1;
          w_dir_nxt   = 1'b1;
          w_timer_nxt = POINT_LD;
          w_state_nxt = S_POINT;
        end else if (i_score_left && i_score_right) begin
          w_timer_nxt = SERVE_LD;
          w_state_nxt = S_SERVE;
        end else if (w_pause_rise) begin
          w_state_nxt = S_PAUSED;
        end
      end
      S_POINT: begin
        if (i_tick) begin
          w_timer_nxt = r_timer - 1'b1;
          if (r_timer == T_ONE) begin
            if (r_left == WIN || r_right == WIN) begin
              w_winner_nxt = (r_right == WIN);
              w_state_nxt  = S_GAME_OVER;
            end else begin
              w_timer_nxt = SERVE_LD;
              w_state_nxt = S_SERVE;
            end
          end
        end
      end
      S_PAUSED: begin
        if (w_pause_rise) w_state_nxt = S_PLAY;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_timer     <= '0;
      r_left      <= '0;
      r_right     <= '0;
      r_dir       <= 1'b0;
      r_winner    <= 1'b0;
      r_start_q   <= 1'b0;
      r_pause_q   <= 1'b0;
      r_ball_hold <= 1'b1;
      r_ball_run  <= 1'b0;
      r_game_over <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_timer     <= w_timer_nxt;
      r_left      <= w_left_nxt;
      r_right     <= w_right_nxt;
      r_dir       <= w_dir_nxt;
      r_winner    <= w_winner_nxt;
      r_start_q   <= i_start;
      r_pause_q   <= i_pause;
      // Decoded from the next state so they line up with r_state.
      r_ball_hold <= (w_state_nxt inside {S_IDLE, S_SERVE, S_POINT, S_GAME_OVER});
      r_ball_run  <= (w_state_nxt == S_PLAY);
      r_game_over <= (w_state_nxt == S_GAME_OVER);
    end
  end

  assign o_ball_hold   = r_ball_hold;
  assign o_ball_run    = r_ball_run;
  assign o_serve_dir   = r_dir;
  assign o_left_score  = r_left;
  assign o_right_score = r_right;
  assign o_game_over   = r_game_over;
  assign o_winner      = r_winner;
  assign o_state       = r_state;

endmodule
